// File: rtl/mac_pe_stw_multi.sv
// mac_pe_stw_multi: a systolic multiply-accumulate processing element with a built-in
// self-test window (STW).
//
// Normal operation: left_in/top_in are registered each cycle. The PE then computes
// sum = low(left_in_reg * op2) + add, with two's complement wrap-around. Here op2 is either
// the stationary operand or top_in_reg, and add is either top_in_reg or the accumulator.
// right_out forwards left_in_reg. bottom_out carries top_in_reg or the accumulator.
//
// Self-test: NUM_VEC vectors {op1, op2, add, expected} are held in a small buffer.
// stw_start runs every vector through the same multiplier/adder, one vector per cycle,
// and counts mismatches. The run ends in a one-cycle DONE state, where the results are
// published and pe_faulty is set if the count reaches FAIL_THRESH. While pe_faulty is set,
// the accumulator bypasses the arithmetic and loads top_in_reg.
//
// Ports: clk/rst (sync, active-high); stall, fsm_op2_select_in, fsm_out_select_in,
// stat_bit_in; left_in/top_in -> right_out/bottom_out; fault_inject[1:0]; stw_load_*
// vector write port; stw_start/stw_clear controls; stw_busy/stw_done/stw_pass/
// stw_fail_count/pe_faulty status.
module mac_pe_stw_multi #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_VEC     = 4,
  parameter int FAIL_THRESH = 1,
  localparam int IdxW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
  localparam int CntW = $clog2(NUM_VEC + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 fsm_op2_select_in,
  input  logic                 fsm_out_select_in,
  input  logic                 stat_bit_in,
  input  logic [WORD_SIZE-1:0] left_in,
  input  logic [WORD_SIZE-1:0] top_in,
  output logic [WORD_SIZE-1:0] right_out,
  output logic [WORD_SIZE-1:0] bottom_out,
  input  logic [1:0]           fault_inject,
  input  logic                 stw_load_en,
  input  logic [IdxW-1:0]      stw_load_idx,
  input  logic [WORD_SIZE-1:0] stw_mult_op1,
  input  logic [WORD_SIZE-1:0] stw_mult_op2,
  input  logic [WORD_SIZE-1:0] stw_add_op,
  input  logic [WORD_SIZE-1:0] stw_expected,
  input  logic                 stw_start,
  input  logic                 stw_clear,
  output logic                 stw_busy,
  output logic                 stw_done,
  output logic                 stw_pass,
  output logic [CntW-1:0]      stw_fail_count,
  output logic                 pe_faulty
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef struct packed {
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] op2;
    logic [WORD_SIZE-1:0] add;
    logic [WORD_SIZE-1:0] exp;
  } vec_t;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VEC - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      vec_idx_q, vec_idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_run;
  logic [CntW-1:0]      fail_count_q, fail_count_d;
  logic                 pass_q, pass_d;
  logic                 faulty_q, faulty_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WORD_SIZE-1:0] left_in_q, left_in_d;
  logic [WORD_SIZE-1:0] top_in_q, top_in_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] stationary_q, stationary_d;
  vec_t                 vec_q [NUM_VEC];
  vec_t                 vec_d [NUM_VEC];

  vec_t                 cur_vec;
  logic [WORD_SIZE-1:0] mult_op2, add_op, op_a, op_b, op_c, product, sum;
  logic                 in_idle, in_run, mismatch;

  assign in_idle = (state_q == StIdle);
  assign in_run  = (state_q == StRun);
  assign cur_vec = vec_q[vec_idx_q];

  // One shared multiplier/adder: self-test vectors borrow it during RUN.
  always_comb begin
    mult_op2 = stat_bit_in ? stationary_q : top_in_q;
    add_op   = stat_bit_in ? top_in_q : acc_q;
    if (in_run) begin
      op_a = cur_vec.op1;
      op_b = cur_vec.op2;
      op_c = cur_vec.add;
    end else begin
      op_a = left_in_q;
      op_b = mult_op2;
      op_c = add_op;
    end
    product = op_a * op_b;  // low WORD_SIZE bits are identical for signed and unsigned
    if (fault_inject[0]) begin
      product = {WORD_SIZE{fault_inject[1]}};
    end
    sum = product + op_c;
  end

  assign mismatch = in_run && (sum != cur_vec.exp);
  assign cnt_run  = cnt_q + CntW'(mismatch);

  // Datapath registers and vector buffer.
  always_comb begin
    left_in_d    = left_in_q;
    top_in_d     = top_in_q;
    acc_d        = acc_q;
    stationary_d = stationary_q;
    vec_d        = vec_q;
    if (in_idle && !stall) begin
      left_in_d = left_in;
      top_in_d  = top_in;
      acc_d     = faulty_q ? top_in_q : sum;
      if (fsm_op2_select_in) begin
        stationary_d = top_in;
      end
    end
    if (in_idle && stw_load_en && (int'(stw_load_idx) < NUM_VEC)) begin
      vec_d[stw_load_idx] = '{op1: stw_mult_op1, op2: stw_mult_op2,
                              add: stw_add_op, exp: stw_expected};
    end
  end

  // Self-test sequencing.
  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    cnt_d        = cnt_q;
    fail_count_d = fail_count_q;
    pass_d       = pass_q;
    faulty_d     = faulty_q;
    unique case (state_q)
      StIdle: begin
        // A clear arriving with a start still lets the run begin.
        if (stw_clear) begin
          faulty_d = 1'b0;
        end
        if (stw_start) begin
          state_d   = StRun;
          vec_idx_d = '0;
          cnt_d     = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_run;
        if (vec_idx_q == LastIdx) begin
          state_d      = StDone;
          fail_count_d = cnt_run;
          pass_d       = (cnt_run == '0);
          if (int'(cnt_run) >= FAIL_THRESH) begin
            faulty_d = 1'b1;
          end
        end else begin
          vec_idx_d = vec_idx_q + IdxW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_idx_q    <= '0;
      cnt_q        <= '0;
      fail_count_q <= '0;
      pass_q       <= 1'b1;
      faulty_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      left_in_q    <= '0;
      top_in_q     <= '0;
      acc_q        <= '0;
      stationary_q <= '0;
      for (int i = 0; i < NUM_VEC; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      cnt_q        <= cnt_d;
      fail_count_q <= fail_count_d;
      pass_q       <= pass_d;
      faulty_q     <= faulty_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      left_in_q    <= left_in_d;
      top_in_q     <= top_in_d;
      acc_q        <= acc_d;
      stationary_q <= stationary_d;
      vec_q        <= vec_d;
    end
  end

  assign right_out      = left_in_q;
  assign bottom_out     = fsm_out_select_in ? acc_q : top_in_q;
  assign stw_busy       = busy_q;
  assign stw_done       = done_q;
  assign stw_pass       = pass_q;
  assign stw_fail_count = fail_count_q;
  assign pe_faulty      = faulty_q;

endmodule

// File: tb/tb_mac_pe_stw_multi.sv
// Directed bench for mac_pe_stw_multi (default parameters: 16-bit, 4 vectors, threshold 1).
module tb_mac_pe_stw_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        fsm_op2_select_in = 1'b0;
  logic        fsm_out_select_in = 1'b0;
  logic        stat_bit_in = 1'b0;
  logic [15:0] left_in = '0;
  logic [15:0] top_in = '0;
  logic [15:0] right_out;
  logic [15:0] bottom_out;
  logic [1:0]  fault_inject = '0;
  logic        stw_load_en = 1'b0;
  logic [1:0]  stw_load_idx = '0;
  logic [15:0] stw_mult_op1 = '0;
  logic [15:0] stw_mult_op2 = '0;
  logic [15:0] stw_add_op = '0;
  logic [15:0] stw_expected = '0;
  logic        stw_start = 1'b0;
  logic        stw_clear = 1'b0;
  logic        stw_busy;
  logic        stw_done;
  logic        stw_pass;
  logic [2:0]  stw_fail_count;
  logic        pe_faulty;

  int checks = 0;
  int failures = 0;

  mac_pe_stw_multi dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .fsm_op2_select_in (fsm_op2_select_in),
    .fsm_out_select_in (fsm_out_select_in),
    .stat_bit_in       (stat_bit_in),
    .left_in           (left_in),
    .top_in            (top_in),
    .right_out         (right_out),
    .bottom_out        (bottom_out),
    .fault_inject      (fault_inject),
    .stw_load_en       (stw_load_en),
    .stw_load_idx      (stw_load_idx),
    .stw_mult_op1      (stw_mult_op1),
    .stw_mult_op2      (stw_mult_op2),
    .stw_add_op        (stw_add_op),
    .stw_expected      (stw_expected),
    .stw_start         (stw_start),
    .stw_clear         (stw_clear),
    .stw_busy          (stw_busy),
    .stw_done          (stw_done),
    .stw_pass          (stw_pass),
    .stw_fail_count    (stw_fail_count),
    .pe_faulty         (pe_faulty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_vec(input logic [1:0] idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] e);
    stw_load_en  = 1'b1;
    stw_load_idx = idx;
    stw_mult_op1 = a;
    stw_mult_op2 = b;
    stw_add_op   = c;
    stw_expected = e;
    tick();
    stw_load_en  = 1'b0;
  endtask

  // Start a run (stw_clear as already driven), then check timing and published results.
  task automatic do_run(input string tag, input logic [2:0] exp_cnt, input logic exp_pass,
                        input logic exp_faulty_run, input logic exp_faulty);
    stw_start = 1'b1;
    tick();
    stw_start = 1'b0;
    stw_clear = 1'b0;
    check({tag, "_busy_run"}, 32'(stw_busy), 32'd1);
    check({tag, "_faulty_run"}, 32'(pe_faulty), 32'(exp_faulty_run));
    tick();
    tick();
    tick();
    check({tag, "_done_early"}, 32'(stw_done), 32'd0);
    tick();
    check({tag, "_done"}, 32'(stw_done), 32'd1);
    check({tag, "_count"}, 32'(stw_fail_count), 32'(exp_cnt));
    check({tag, "_pass"}, 32'(stw_pass), 32'(exp_pass));
    check({tag, "_faulty"}, 32'(pe_faulty), 32'(exp_faulty));
    tick();
    check({tag, "_done_clr"}, 32'(stw_done), 32'd0);
    check({tag, "_busy_clr"}, 32'(stw_busy), 32'd0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_right", 32'(right_out), 32'h0);
    check("rst_bottom_top", 32'(bottom_out), 32'h0);
    check("rst_busy", 32'(stw_busy), 32'd0);
    check("rst_done", 32'(stw_done), 32'd0);
    check("rst_count", 32'(stw_fail_count), 32'd0);
    check("rst_pass", 32'(stw_pass), 32'd1);
    check("rst_faulty", 32'(pe_faulty), 32'd0);
    fsm_out_select_in = 1'b1;
    #1;
    check("rst_bottom_acc", 32'(bottom_out), 32'h0);

    // Good vectors: 3*5+2=17, -2*4+1=-7, 0*9+6=6, 7*1+0=7.
    load_vec(2'd0, 16'd3, 16'd5, 16'd2, 16'd17);
    load_vec(2'd1, 16'hFFFE, 16'd4, 16'd1, 16'hFFF9);
    load_vec(2'd2, 16'd0, 16'd9, 16'd6, 16'd6);
    load_vec(2'd3, 16'd7, 16'd1, 16'd0, 16'd7);

    // Run 1: clean, with a stray start and a stray load while running.
    stw_start = 1'b1;
    tick();
    stw_start = 1'b0;
    check("r1_busy", 32'(stw_busy), 32'd1);
    check("r1_done0", 32'(stw_done), 32'd0);
    tick();
    stw_start    = 1'b1;
    stw_load_en  = 1'b1;
    stw_load_idx = 2'd0;
    stw_mult_op1 = 16'h1111;
    stw_expected = 16'h0BAD;
    tick();
    stw_start   = 1'b0;
    stw_load_en = 1'b0;
    check("r1_done_e2", 32'(stw_done), 32'd0);
    tick();
    check("r1_done_e3", 32'(stw_done), 32'd0);
    tick();
    check("r1_done", 32'(stw_done), 32'd1);
    check("r1_count", 32'(stw_fail_count), 32'd0);
    check("r1_pass", 32'(stw_pass), 32'd1);
    check("r1_faulty", 32'(pe_faulty), 32'd0);
    tick();
    check("r1_done_clr", 32'(stw_done), 32'd0);
    check("r1_busy_clr", 32'(stw_busy), 32'd0);
    tick();
    check("r1_no_restart", 32'(stw_busy), 32'd0);

    // Run 2: product stuck at zero. Vector 2 already has a zero product, so it still
    // matches: sums 2,1,6,0 against 17,-7,6,7 give 3 mismatches.
    fault_inject = 2'b01;
    do_run("r2", 3'd3, 1'b0, 1'b0, 1'b1);
    check("r2_count_hold", 32'(stw_fail_count), 32'd3);
    fault_inject = 2'b00;

    // Faulty PE bypasses the MAC: accumulator takes top_in_reg.
    top_in  = 16'd10;
    left_in = 16'd3;
    tick();
    tick();
    check("bypass_acc", 32'(bottom_out), 32'd10);
    check("bypass_right", 32'(right_out), 32'd3);

    // Run 3: clear plus start together, stall held high (must not pause the run).
    stall     = 1'b1;
    stw_clear = 1'b1;
    do_run("r3", 3'd0, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;

    // Weight-stationary MAC: stationary=3, then 4*3+5=17.
    fsm_op2_select_in = 1'b1;
    top_in  = 16'd3;
    left_in = 16'd0;
    tick();
    fsm_op2_select_in = 1'b0;
    stat_bit_in = 1'b1;
    left_in = 16'd4;
    top_in  = 16'd5;
    tick();
    tick();
    check("ws_acc", 32'(bottom_out), 32'd17);
    check("ws_right", 32'(right_out), 32'd4);
    fsm_out_select_in = 1'b0;
    #1;
    check("ws_bottom_top", 32'(bottom_out), 32'd5);
    fsm_out_select_in = 1'b1;

    // Wrap: stationary=4, 0x4000*4 = 0x10000 -> 0, plus top_in_reg=1.
    fsm_op2_select_in = 1'b1;
    top_in = 16'd4;
    tick();
    fsm_op2_select_in = 1'b0;
    left_in = 16'h4000;
    top_in  = 16'd1;
    tick();
    tick();
    check("wrap_acc", 32'(bottom_out), 32'd1);

    // Stall freezes datapath.
    stall   = 1'b1;
    left_in = 16'd7;
    top_in  = 16'd8;
    tick();
    check("stall_right", 32'(right_out), 32'h4000);
    check("stall_acc", 32'(bottom_out), 32'd1);
    stall = 1'b0;

    // Output-stationary path: 0x4000*1 + 1 = 0x4001, then 2*3 + 0x4001 = 0x4007.
    stat_bit_in = 1'b0;
    left_in = 16'd2;
    top_in  = 16'd3;
    tick();
    check("os_acc1", 32'(bottom_out), 32'h4001);
    tick();
    check("os_acc2", 32'(bottom_out), 32'h4007);

    // Run 4: product stuck at all-ones, sums 1,0,5,-1 -> all 4 mismatch.
    fault_inject = 2'b11;
    do_run("r4", 3'd4, 1'b0, 1'b0, 1'b1);
    fault_inject = 2'b00;

    // Reset in the middle of a run: everything back to reset values, no done pulse.
    stw_start = 1'b1;
    tick();
    stw_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_busy", 32'(stw_busy), 32'd0);
    check("rr_done", 32'(stw_done), 32'd0);
    check("rr_count", 32'(stw_fail_count), 32'd0);
    check("rr_pass", 32'(stw_pass), 32'd1);
    check("rr_faulty", 32'(pe_faulty), 32'd0);
    check("rr_right", 32'(right_out), 32'h0);
    check("rr_bottom_acc", 32'(bottom_out), 32'h0);
    left_in = 16'd0;
    top_in  = 16'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_no_done", 32'(stw_done), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
